// File: rtl/sign_mag_to_twos.sv
// sign_mag_to_twos: bit-serial sign-magnitude to two's-complement converter; ports clk, rst_n, start, A (in) -> B, busy, done, Cout, NZ (out)
module sign_mag_to_twos #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Cout,
    output logic             NZ
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-2:0] res, res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, c_nxt, t, last;
    always_comb begin
        t         = a[cnt] ^ a[WIDTH-1];
        c_nxt     = t & carry;
        last      = cnt == CW'(WIDTH - 2);
        res_nxt   = res;
        res_nxt[cnt] = t ^ carry;
        state_nxt = state == IDLE ? (start ? CONV : IDLE) :
                    state == CONV ? (last ? DONE : CONV) : IDLE;
        busy      = state == CONV;
        done      = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a     <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            B     <= '0;
            Cout  <= 1'b0;
            NZ    <= 1'b0;
        end else if (state == IDLE && start) begin
            a     <= A;
            carry <= A[WIDTH-1];
            cnt   <= '0;
        end else if (state == CONV) begin
            res   <= res_nxt;
            carry <= c_nxt;
            cnt   <= cnt + 1'b1;
            if (last) begin
                B    <= {a[WIDTH-1] & ~c_nxt, res_nxt};
                Cout <= c_nxt;
                NZ   <= a[WIDTH-1] & c_nxt;
            end
        end
endmodule

// File: tb/tb_sign_mag_to_twos.sv
// tb_sign_mag_to_twos: directed scoreboard bench for sign_mag_to_twos
module tb_sign_mag_to_twos;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0] A = '0, B;
    logic       busy, done, Cout, NZ;
    int         checks = 0, errors = 0, cyc = 0;
    logic [9:0] sb[$];

    sign_mag_to_twos #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A),
        .B(B), .busy(busy), .done(done), .Cout(Cout), .NZ(NZ)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (rst_n && done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
            logic [9:0] e;
            e = sb.pop_front();
            chk("B", B, e[9:2]);
            chk("Cout", Cout, e[1]);
            chk("NZ", NZ, e[0]);
            chk("busy_in_done", busy, 0);
        end
    end

    task automatic run(input logic [7:0] a, input logic [7:0] eb, input logic ec, input logic enz);
        int n;
        @(negedge clk);
        A = a; start = 1'b1; sb.push_back({eb, ec, enz});
        @(negedge clk);
        start = 1'b0; A = 8'($urandom);
        n = 0;
        while (!done && n < 20) begin
            if (busy) n++;
            @(negedge clk);
        end
        chk("latency", n, 7);
        @(negedge clk);
        chk("done_width", done, 0);
    endtask

    initial begin
        int t0, t1, t2, n;
        #2;
        chk("rst_B", B, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_Cout_NZ", {Cout, NZ}, 0);
        #10 rst_n = 1'b1;
        run(8'h85, 8'hFB, 0, 0);
        run(8'h05, 8'h05, 0, 0);
        run(8'h7F, 8'h7F, 0, 0);
        run(8'h80, 8'h00, 1, 1);
        run(8'hFF, 8'h81, 0, 0);
        repeat (3) @(negedge clk);
        chk("hold_B", B, 8'h81);
        // second start during conversion must be ignored
        @(negedge clk);
        A = 8'h83; start = 1'b1; sb.push_back({8'hFD, 1'b0, 1'b0});
        @(negedge clk);
        A = 8'h01;
        n = 0;
        while (!done && n < 20) begin n++; @(negedge clk); end
        chk("ignore_start_done", done, 1);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignore_start_idle", busy, 0);
        // asynchronous reset on 3rd CONV cycle
        A = 8'h85; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_B", B, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done_B", B, 0);
        run(8'h81, 8'hFF, 0, 0);
        // back-to-back with start held high
        @(negedge clk);
        A = 8'h82; start = 1'b1;
        repeat (3) sb.push_back({8'hFE, 1'b0, 1'b0});
        t0 = 0; t1 = 0; t2 = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!done && n < 20) begin n++; @(negedge clk); end
            if (k == 0) t0 = cyc; else if (k == 1) t1 = cyc; else t2 = cyc;
        end
        start = 1'b0;
        chk("period1", t1 - t0, 9);
        chk("period2", t2 - t1, 9);
        repeat (12) @(negedge clk);
        chk("pending", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
